// File: rtl/bcd_conv_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift-and-adjust step per clock.
// Optional leading-zero blank mask is enabled by defining BCD_ZERO_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last conversion
// SHIFT | one adjust+shift step per edge, BIN_W steps in total
module bcd_conv_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  valid,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [63:0]      MAX      = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [SR_W-1:0]  shreg;
  logic [SR_W-1:0]  step;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;

  // Adjust every BCD nibble >= 5 by +3, then shift the whole register left by one.
  always_comb begin
    logic [SR_W-1:0] adj;
    logic [3:0]      nib;
    adj = shreg;
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = adj[BIN_W + 4*i +: 4];
      if (nib >= 4'd5)
        adj[BIN_W + 4*i +: 4] = nib + 4'd3;
    end
    step = {adj[SR_W-2:0], 1'b0};
  end

`ifdef BCD_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_d;

  // blank[i] set when digit i and every digit above it are zero; units never blanked.
  always_comb begin
    logic zero_above;
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (step[BIN_W + 4*i +: 4] == 4'd0);
      blank_d[i] = zero_above;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      bcd   <= '0;
`ifdef BCD_ZERO_BLANK_EN
      blank <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            shreg <= {{BCD_W{1'b0}}, bin};
            cnt   <= '0;
            busy  <= 1'b1;
            ovf_q <= (64'(bin) > MAX);
          end
        end
        SHIFT: begin
          shreg <= step;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b1;
            ovf   <= ovf_q;
            // Out-of-range inputs saturate the display to all nines.
            bcd   <= ovf_q ? {DIGITS{4'h9}} : step[SR_W-1:BIN_W];
`ifdef BCD_ZERO_BLANK_EN
            blank <= ovf_q ? '0 : blank_d;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
